traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor_pkg.sv | 45 ++++
 rtl/traffic_light_monitor_if.sv | 14 +
 rtl/traffic_light_monitor_lamp_decode.sv | 50 +++++
 rtl/traffic_light_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// Shared types, default phase durations and helper functions for the
// traffic light monitor.
package traffic_light_monitor_pkg;

  // Decoded controller phase, in legal sequence order
  typedef enum logic [1:0] {
    PH_NS_G = 2'b00,
    PH_NS_Y = 2'b01,
    PH_EW_G = 2'b10,
    PH_EW_Y = 2'b11
  } phase_e;

  // Tracker lock state
  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_e;

  localparam int unsigned DUR_NS_G_DEF = 5;
  localparam int unsigned DUR_NS_Y_DEF = 2;
  localparam int unsigned DUR_EW_G_DEF = 5;
  localparam int unsigned DUR_EW_Y_DEF = 2;

  localparam int unsigned TICK_W = 4;
  localparam int unsigned CYC_W  = 8;

  // Legal successor of a phase: NS_G -> NS_Y -> EW_G -> EW_Y -> NS_G
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      PH_NS_G: n = PH_NS_Y;
      PH_NS_Y: n = PH_EW_G;
      PH_EW_G: n = PH_EW_Y;
      PH_EW_Y: n = PH_NS_G;
      default: n = PH_NS_G;
    endcase
    return n;
  endfunction

  // True when exactly one lamp of a {g,y,r} triple is lit
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Observed lamp bus of a two-way traffic light controller plus its
// phase-timing strobe.
interface traffic_light_monitor_if;
  logic ns_g;
  logic ns_y;
  logic ns_r;
  logic ew_g;
  logic ew_y;
  logic ew_r;
  logic tick;

  modport master (output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, tick);
  modport slave  (input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, tick);
endinterface

// File: rtl/traffic_light_monitor_lamp_decode.sv
// Combinational decode of the six lamps into a phase code and a
// legal / conflict / encoding-error classification.
module tl_lamp_decode
  import traffic_light_monitor_pkg::*;
(
  input  logic   ns_g,
  input  logic   ns_y,
  input  logic   ns_r,
  input  logic   ew_g,
  input  logic   ew_y,
  input  logic   ew_r,
  output phase_e phase,
  output logic   legal,
  output logic   conflict,
  output logic   encoding_err
);

  logic [2:0] ns_v_s;
  logic [2:0] ew_v_s;
  logic       ns_oh_s;
  logic       ew_oh_s;

  assign ns_v_s  = {ns_g, ns_y, ns_r};
  assign ew_v_s  = {ew_g, ew_y, ew_r};
  assign ns_oh_s = is_onehot3(ns_v_s);
  assign ew_oh_s = is_onehot3(ew_v_s);

  // Classify the pattern; exactly one direction non-red is legal
  always_comb begin
    phase        = PH_NS_G;
    legal        = 1'b0;
    conflict     = 1'b0;
    encoding_err = 1'b0;
    if (!ns_oh_s || !ew_oh_s) begin
      encoding_err = 1'b1;
    end else if (ns_r && ew_r) begin
      encoding_err = 1'b1;
    end else if (!ns_r && !ew_r) begin
      conflict = 1'b1;
    end else begin
      legal = 1'b1;
      if (!ns_r) begin
        phase = ns_g ? PH_NS_G : PH_NS_Y;
      end else begin
        phase = ew_g ? PH_EW_G : PH_EW_Y;
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: decodes observed lamps, tracks the phase
// sequence and per-phase tick durations, and raises sticky error flags.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int unsigned DUR_NS_G = DUR_NS_G_DEF,
  parameter int unsigned DUR_NS_Y = DUR_NS_Y_DEF,
  parameter int unsigned DUR_EW_G = DUR_EW_G_DEF,
  parameter int unsigned DUR_EW_Y = DUR_EW_Y_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  traffic_light_monitor_if.slave         lamp_bus,
  input  logic                           clear_err,
  output logic [1:0]                     phase,
  output logic                           phase_valid,
  output logic                           locked,
  output logic                           err_conflict,
  output logic                           err_encoding,
  output logic                           err_sequence,
  output logic                           err_duration,
  output logic                           err_any,
  output logic [CYC_W-1:0]               cycle_count
);

  // Expected tick count of a phase
  function automatic logic [TICK_W-1:0] dur_of(input phase_e p);
    logic [TICK_W-1:0] d;
    case (p)
      PH_NS_G: d = TICK_W'(DUR_NS_G);
      PH_NS_Y: d = TICK_W'(DUR_NS_Y);
      PH_EW_G: d = TICK_W'(DUR_EW_G);
      PH_EW_Y: d = TICK_W'(DUR_EW_Y);
      default: d = TICK_W'(DUR_NS_G);
    endcase
    return d;
  endfunction

  phase_e            dec_phase_s;
  logic              dec_legal_s;
  logic              dec_conflict_s;
  logic              dec_enc_s;

  trk_state_e        state_r;
  trk_state_e        state_nxt_s;
  phase_e            phase_r;
  phase_e            phase_nxt_s;
  logic              phase_valid_r;
  logic              locked_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [TICK_W-1:0] tick_cnt_nxt_s;
  logic              full_phase_r;
  logic              full_phase_nxt_s;
  logic [CYC_W-1:0]  cycle_cnt_r;
  logic [CYC_W-1:0]  cycle_cnt_nxt_s;
  logic              set_seq_s;
  logic              set_dur_s;
  logic              err_conflict_r;
  logic              err_encoding_r;
  logic              err_sequence_r;
  logic              err_duration_r;
  logic              err_any_r;
  logic              err_conflict_nxt_s;
  logic              err_encoding_nxt_s;
  logic              err_sequence_nxt_s;
  logic              err_duration_nxt_s;

  tl_lamp_decode u_decode (
    .ns_g         (lamp_bus.ns_g),
    .ns_y         (lamp_bus.ns_y),
    .ns_r         (lamp_bus.ns_r),
    .ew_g         (lamp_bus.ew_g),
    .ew_y         (lamp_bus.ew_y),
    .ew_r         (lamp_bus.ew_r),
    .phase        (dec_phase_s),
    .legal        (dec_legal_s),
    .conflict     (dec_conflict_s),
    .encoding_err (dec_enc_s)
  );

  // Tracker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next tracker state: any legal pattern locks, any illegal one drops lock
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SYNC:  state_nxt_s = dec_legal_s ? ST_TRACK : ST_SYNC;
      ST_TRACK: state_nxt_s = dec_legal_s ? ST_TRACK : ST_SYNC;
      default:  state_nxt_s = ST_SYNC;
    endcase
  end

  // Tracker datapath: tick counting, duration/sequence checks, cycle count
  always_comb begin
    phase_nxt_s      = phase_r;
    tick_cnt_nxt_s   = tick_cnt_r;
    full_phase_nxt_s = full_phase_r;
    cycle_cnt_nxt_s  = cycle_cnt_r;
    set_seq_s        = 1'b0;
    set_dur_s        = 1'b0;
    case (state_r)
      ST_SYNC: begin
        tick_cnt_nxt_s = {TICK_W{1'b0}};
        if (dec_legal_s) begin
          phase_nxt_s      = dec_phase_s;
          full_phase_nxt_s = 1'b0;
        end else begin
          phase_nxt_s = phase_r;
        end
      end
      ST_TRACK: begin
        if (!dec_legal_s) begin
          tick_cnt_nxt_s = {TICK_W{1'b0}};
        end else if (dec_phase_s == phase_r) begin
          if (lamp_bus.tick) begin
            if (tick_cnt_r != {TICK_W{1'b1}}) begin
              tick_cnt_nxt_s = tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
            end else begin
              tick_cnt_nxt_s = tick_cnt_r;
            end
            // This tick takes the count to DUR+1: flag the overrun now
            if (full_phase_r && (tick_cnt_r == dur_of(phase_r))) begin
              set_dur_s = 1'b1;
            end else begin
              set_dur_s = 1'b0;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r;
          end
        end else if (dec_phase_s == next_phase(phase_r)) begin
          // Final count of the old phase already includes its last tick
          if (full_phase_r && (tick_cnt_r != dur_of(phase_r))) begin
            set_dur_s = 1'b1;
          end else begin
            set_dur_s = 1'b0;
          end
          phase_nxt_s      = dec_phase_s;
          tick_cnt_nxt_s   = {TICK_W{1'b0}};
          full_phase_nxt_s = 1'b1;
          if (phase_r == PH_EW_Y) begin
            cycle_cnt_nxt_s = cycle_cnt_r + 8'd1;
          end else begin
            cycle_cnt_nxt_s = cycle_cnt_r;
          end
        end else begin
          set_seq_s        = 1'b1;
          phase_nxt_s      = dec_phase_s;
          tick_cnt_nxt_s   = {TICK_W{1'b0}};
          full_phase_nxt_s = 1'b0;
        end
      end
      default: begin
        tick_cnt_nxt_s = {TICK_W{1'b0}};
      end
    endcase
  end

  // Sticky flags: a new error wins over clear_err in the same cycle
  always_comb begin
    err_conflict_nxt_s = (err_conflict_r & ~clear_err) | dec_conflict_s;
    err_encoding_nxt_s = (err_encoding_r & ~clear_err) | dec_enc_s;
    err_sequence_nxt_s = (err_sequence_r & ~clear_err) | set_seq_s;
    err_duration_nxt_s = (err_duration_r & ~clear_err) | set_dur_s;
  end

  // Registered tracker datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r        <= PH_NS_G;
      phase_valid_r  <= 1'b0;
      locked_r       <= 1'b0;
      tick_cnt_r     <= {TICK_W{1'b0}};
      full_phase_r   <= 1'b0;
      cycle_cnt_r    <= {CYC_W{1'b0}};
      err_conflict_r <= 1'b0;
      err_encoding_r <= 1'b0;
      err_sequence_r <= 1'b0;
      err_duration_r <= 1'b0;
      err_any_r      <= 1'b0;
    end else begin
      phase_r        <= phase_nxt_s;
      phase_valid_r  <= dec_legal_s;
      locked_r       <= (state_nxt_s == ST_TRACK);
      tick_cnt_r     <= tick_cnt_nxt_s;
      full_phase_r   <= full_phase_nxt_s;
      cycle_cnt_r    <= cycle_cnt_nxt_s;
      err_conflict_r <= err_conflict_nxt_s;
      err_encoding_r <= err_encoding_nxt_s;
      err_sequence_r <= err_sequence_nxt_s;
      err_duration_r <= err_duration_nxt_s;
      err_any_r      <= err_conflict_nxt_s | err_encoding_nxt_s |
                        err_sequence_nxt_s | err_duration_nxt_s;
    end
  end

  assign phase        = phase_r;
  assign phase_valid  = phase_valid_r;
  assign locked       = locked_r;
  assign err_conflict = err_conflict_r;
  assign err_encoding = err_encoding_r;
  assign err_sequence = err_sequence_r;
  assign err_duration = err_duration_r;
  assign err_any      = err_any_r;
  assign cycle_count  = cycle_cnt_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (default 5/2/5/2).
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_err;
  logic [1:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       err_conflict;
  logic       err_encoding;
  logic       err_sequence;
  logic       err_duration;
  logic       err_any;
  logic [7:0] cycle_count;

  int n_pass   = 0;
  int n_checks = 0;

  traffic_light_monitor_if bus ();

  traffic_light_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lamp_bus     (bus),
    .clear_err    (clear_err),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .locked       (locked),
    .err_conflict (err_conflict),
    .err_encoding (err_encoding),
    .err_sequence (err_sequence),
    .err_duration (err_duration),
    .err_any      (err_any),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Apply one lamp pattern for one clock; outputs are sampled 1 time unit after the edge
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic t, input logic ce);
    {bus.ns_g, bus.ns_y, bus.ns_r} = ns;
    {bus.ew_g, bus.ew_y, bus.ew_r} = ew;
    bus.tick  = t;
    clear_err = ce;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  // One phase: a first cycle without tick, then n ticking cycles
  task automatic run_phase(input logic [2:0] ns, input logic [2:0] ew, input int n);
    step(ns, ew, 1'b0, 1'b0);
    repeat (n) step(ns, ew, 1'b1, 1'b0);
  endtask

  task automatic full_cycle();
    run_phase(G, R, 5);
    run_phase(Y, R, 2);
    run_phase(R, G, 5);
    run_phase(R, Y, 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_err = 1'b0;
    {bus.ns_g, bus.ns_y, bus.ns_r, bus.ew_g, bus.ew_y, bus.ew_r, bus.tick} = 7'd0;
    #12;
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
    n_checks++; if (phase !== 2'b00 || phase_valid !== 1'b0) $display("FAIL reset_phase: got %b/%b want 00/0", phase, phase_valid); else n_pass++;
    n_checks++; if (err_any !== 1'b0 || cycle_count !== 8'd0) $display("FAIL reset_err_cnt: got %b/%0d want 0/0", err_any, cycle_count); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_legal_cycles();
    step(G, R, 1'b0, 1'b0);
    n_checks++; if (locked !== 1'b1 || phase !== 2'b00 || phase_valid !== 1'b1) $display("FAIL first_lock: got %b/%b/%b want 1/00/1", locked, phase, phase_valid); else n_pass++;
    repeat (5) step(G, R, 1'b1, 1'b0);
    run_phase(Y, R, 2);
    run_phase(R, G, 5);
    run_phase(R, Y, 2);
    full_cycle();
    full_cycle();
    n_checks++; if (err_any !== 1'b0) $display("FAIL legal_no_err: got %b want 0", err_any); else n_pass++;
    n_checks++; if (cycle_count !== 8'd2) $display("FAIL legal_cycles: got %0d want 2", cycle_count); else n_pass++;
    n_checks++; if (phase !== 2'b11 || locked !== 1'b1) $display("FAIL legal_end_phase: got %b/%b want 11/1", phase, locked); else n_pass++;
  endtask

  task automatic test_conflict();
    step(G, G, 1'b0, 1'b0);
    n_checks++; if (err_conflict !== 1'b1 || locked !== 1'b0 || phase_valid !== 1'b0) $display("FAIL conflict_set: got %b/%b/%b want 1/0/0", err_conflict, locked, phase_valid); else n_pass++;
    n_checks++; if (phase !== 2'b11 || err_encoding !== 1'b0) $display("FAIL conflict_hold: got %b/%b want 11/0", phase, err_encoding); else n_pass++;
    step(G, R, 1'b0, 1'b0);
    n_checks++; if (locked !== 1'b1 || phase !== 2'b00 || err_conflict !== 1'b1 || err_sequence !== 1'b0) $display("FAIL conflict_relock: got %b/%b/%b/%b want 1/00/1/0", locked, phase, err_conflict, err_sequence); else n_pass++;
    step(G, R, 1'b0, 1'b1);
    n_checks++; if (err_conflict !== 1'b0 || cycle_count !== 8'd2) $display("FAIL conflict_clear: got %b/%0d want 0/2", err_conflict, cycle_count); else n_pass++;
  endtask

  task automatic test_duration();
    repeat (5) step(G, R, 1'b1, 1'b0);
    run_phase(Y, R, 2);
    run_phase(R, G, 5);
    run_phase(R, Y, 2);
    step(G, R, 1'b0, 1'b0);
    repeat (5) step(G, R, 1'b1, 1'b0);
    n_checks++; if (err_duration !== 1'b0) $display("FAIL dur_at_limit: got %b want 0", err_duration); else n_pass++;
    step(G, R, 1'b1, 1'b0);
    n_checks++; if (err_duration !== 1'b1) $display("FAIL dur_overrun: got %b want 1", err_duration); else n_pass++;
    step(Y, R, 1'b0, 1'b0);
    step(Y, R, 1'b1, 1'b1);
    n_checks++; if (err_duration !== 1'b0 || locked !== 1'b1) $display("FAIL dur_clear: got %b/%b want 0/1", err_duration, locked); else n_pass++;
    step(Y, R, 1'b1, 1'b0);
    run_phase(R, G, 5);
    run_phase(R, Y, 2);
    step(G, R, 1'b0, 1'b0);
    repeat (4) step(G, R, 1'b1, 1'b0);
    n_checks++; if (err_duration !== 1'b0) $display("FAIL dur_short_early: got %b want 0", err_duration); else n_pass++;
    step(Y, R, 1'b0, 1'b1);
    n_checks++; if (err_duration !== 1'b1) $display("FAIL dur_short_with_clear: got %b want 1", err_duration); else n_pass++;
    step(Y, R, 1'b1, 1'b1);
    step(Y, R, 1'b1, 1'b0);
    n_checks++; if (err_duration !== 1'b0 || cycle_count !== 8'd4) $display("FAIL dur_after: got %b/%0d want 0/4", err_duration, cycle_count); else n_pass++;
  endtask

  task automatic test_sequence();
    run_phase(R, G, 5);
    run_phase(R, Y, 2);
    run_phase(G, R, 5);
    step(R, G, 1'b0, 1'b0);
    n_checks++; if (err_sequence !== 1'b1 || err_duration !== 1'b0) $display("FAIL seq_skip: got %b/%b want 1/0", err_sequence, err_duration); else n_pass++;
    n_checks++; if (locked !== 1'b1 || phase !== 2'b10) $display("FAIL seq_relock: got %b/%b want 1/10", locked, phase); else n_pass++;
    repeat (3) step(R, G, 1'b1, 1'b0);
    step(R, Y, 1'b0, 1'b0);
    n_checks++; if (err_duration !== 1'b0 || phase !== 2'b11) $display("FAIL seq_partial_nodur: got %b/%b want 0/11", err_duration, phase); else n_pass++;
    step(R, Y, 1'b1, 1'b1);
    n_checks++; if (err_any !== 1'b0 || cycle_count !== 8'd5) $display("FAIL seq_clear: got %b/%0d want 0/5", err_any, cycle_count); else n_pass++;
  endtask

  task automatic test_encoding();
    step(O, R, 1'b0, 1'b0);
    n_checks++; if (err_encoding !== 1'b1 || phase_valid !== 1'b0 || err_conflict !== 1'b0 || locked !== 1'b0) $display("FAIL enc_dark: got %b/%b/%b/%b want 1/0/0/0", err_encoding, phase_valid, err_conflict, locked); else n_pass++;
    step(R, R, 1'b0, 1'b1);
    n_checks++; if (err_encoding !== 1'b1 || phase_valid !== 1'b0) $display("FAIL enc_allred: got %b/%b want 1/0", err_encoding, phase_valid); else n_pass++;
    step(G, R, 1'b0, 1'b1);
    n_checks++; if (err_encoding !== 1'b0 || phase_valid !== 1'b1 || locked !== 1'b1) $display("FAIL enc_clear: got %b/%b/%b want 0/1/1", err_encoding, phase_valid, locked); else n_pass++;
    step(Y, Y, 1'b0, 1'b1);
    n_checks++; if (err_conflict !== 1'b1 || err_any !== 1'b1) $display("FAIL enc_conflict_clear: got %b/%b want 1/1", err_conflict, err_any); else n_pass++;
    step(R, G, 1'b0, 1'b1);
    n_checks++; if (err_any !== 1'b0 || locked !== 1'b1 || phase !== 2'b10) $display("FAIL enc_recover: got %b/%b/%b want 0/1/10", err_any, locked, phase); else n_pass++;
  endtask

  task automatic test_reset_midphase();
    step(O, O, 1'b0, 1'b0);
    step(R, G, 1'b0, 1'b0);
    step(R, G, 1'b1, 1'b0);
    n_checks++; if (locked !== 1'b1 || err_encoding !== 1'b1 || cycle_count !== 8'd5) $display("FAIL prereset: got %b/%b/%0d want 1/1/5", locked, err_encoding, cycle_count); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0 || phase !== 2'b00 || phase_valid !== 1'b0) $display("FAIL async_reset_state: got %b/%b/%b want 0/00/0", locked, phase, phase_valid); else n_pass++;
    n_checks++; if (err_any !== 1'b0 || err_encoding !== 1'b0 || cycle_count !== 8'd0) $display("FAIL async_reset_err: got %b/%b/%0d want 0/0/0", err_any, err_encoding, cycle_count); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_held: got %b want 0", locked); else n_pass++;
    rst_n = 1'b1;
    step(R, G, 1'b0, 1'b0);
    repeat (2) step(R, G, 1'b1, 1'b0);
    step(R, Y, 1'b0, 1'b0);
    n_checks++; if (err_duration !== 1'b0 || locked !== 1'b1 || phase !== 2'b11) $display("FAIL post_reset_partial: got %b/%b/%b want 0/1/11", err_duration, locked, phase); else n_pass++;
    repeat (2) step(R, Y, 1'b1, 1'b0);
    step(G, R, 1'b0, 1'b0);
    n_checks++; if (cycle_count !== 8'd1 || err_any !== 1'b0) $display("FAIL post_reset_cycle: got %0d/%b want 1/0", cycle_count, err_any); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_legal_cycles();
    test_conflict();
    test_duration();
    test_sequence();
    test_encoding();
    test_reset_midphase();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
